fifo_stream_reader: RTL and testbench

//  Read-side drain engine for the synchronous FIFO. It pulls words through the

---
 rtl/fifo_stream_reader_if.sv | 28 ++
 rtl/fifo_stream_reader.sv | 71 +++++++
 tb/tb_fifo_stream_reader.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_reader_if
// Description : FIFO read port plus valid/ready stream bus for the reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_r_en;
    logic [DATA_WIDTH-1:0] fifo_r_data;
    logic                  fifo_empty;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        output fifo_r_en, m_valid, m_data, m_last,
        input  fifo_r_data, fifo_empty, m_ready
    );

    modport slave (
        input  fifo_r_en, m_valid, m_data, m_last,
        output fifo_r_data, fifo_empty, m_ready
    );
endinterface
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_reader
// Description : Drains a registered-read FIFO into a valid/ready stream with
//               a 2-entry prefetch buffer and m_last every BURST_LEN beats.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    fifo_stream_reader_if.master bus
);
    localparam int                 c_CNT_W    = $clog2(BURST_LEN) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(BURST_LEN - 1);

    logic [DATA_WIDTH-1:0] r_buf [2];
    logic [1:0]            r_occ;
    logic                  r_inflight;
    logic [c_CNT_W-1:0]    r_beat_cnt;

    logic                  w_valid;
    logic                  w_last;
    logic                  w_pop;
    logic [2:0]            w_level;
    logic                  w_wr_sel;

    always_comb begin
        w_valid  = (r_occ != 2'd0);
        w_last   = w_valid && (r_beat_cnt == c_LAST_CNT);
        w_pop    = w_valid && bus.m_ready;
        // Words owned after this edge: buffered plus in flight, minus the one leaving.
        w_level  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_wr_sel = ((r_occ - {1'b0, w_pop}) != 2'd0);
    end

    assign bus.fifo_r_en = !rst && !bus.fifo_empty && (w_level < 3'd2);
    assign bus.m_valid   = w_valid;
    assign bus.m_data    = r_buf[0];
    assign bus.m_last    = w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_inflight <= bus.fifo_r_en;
            r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
            if (w_pop) begin
                r_beat_cnt <= w_last ? '0 : r_beat_cnt + c_CNT_W'(1);
            end
        end
    end

    // Entry 0 is always the head; a pop shifts, an arriving word lands behind.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_buf[0] <= r_buf[1];
        end
        if (r_inflight) begin
            r_buf[w_wr_sel] <= bus.fifo_r_data;
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(r_inflight && !w_pop && (r_occ == 2'd2)));
endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_stream_reader
// Description : Randomized and directed self-checking bench for the reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;
    localparam int DW = 32;
    localparam int BL = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] src_q [$];
    logic [31:0] exp_q [$];
    int          acc_cyc [$];
    bit          rd_last = 1'b0;
    bit          gate_empty = 1'b0;
    int          beat_n = 0;
    int          n_acc = 0;
    int          n_rd = 0;
    int          cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, compare against the model, then emulate the FIFO.
    task automatic step(input bit r, input bit rdy, input bit chk_rst_out);
        bit          empty;
        bit          v_exp;
        bit          pop_exp;
        bit          en_exp;
        bit          did_rd;
        logic [31:0] w;
        w = '0;
        @(negedge clk);
        rst          = r;
        bus.m_ready  = rdy;
        empty        = (src_q.size() == 0) || gate_empty;
        bus.fifo_empty = empty;
        #1;
        did_rd = bus.fifo_r_en && !empty;
        if (r) begin
            check_eq("rst_r_en", {31'b0, bus.fifo_r_en}, 32'd0);
            if (chk_rst_out) begin
                check_eq("rst_m_valid", {31'b0, bus.m_valid}, 32'd0);
                check_eq("rst_m_last", {31'b0, bus.m_last}, 32'd0);
            end
            exp_q.delete();
            beat_n  = 0;
            rd_last = 1'b0;
            did_rd  = 1'b0;
        end else begin
            // Words read two or more cycles ago and not yet accepted are visible.
            v_exp   = (exp_q.size() - (rd_last ? 1 : 0)) > 0;
            pop_exp = v_exp && rdy;
            en_exp  = !empty && ((exp_q.size() - (pop_exp ? 1 : 0)) < 2);
            check_eq("fifo_r_en", {31'b0, bus.fifo_r_en}, {31'b0, en_exp});
            check_eq("m_valid", {31'b0, bus.m_valid}, {31'b0, v_exp});
            if (v_exp) begin
                check_eq("m_data", bus.m_data, exp_q[0]);
                check_eq("m_last", {31'b0, bus.m_last}, {31'b0, (beat_n % BL) == BL - 1});
            end
            if (pop_exp) begin
                void'(exp_q.pop_front());
                beat_n++;
                n_acc++;
                acc_cyc.push_back(cyc);
            end
            if (did_rd) begin
                w = src_q.pop_front();
                exp_q.push_back(w);
                n_rd++;
            end
            rd_last = did_rd;
        end
        @(posedge clk);
        #1;
        cyc++;
        bus.fifo_r_data = did_rd ? w : $urandom();
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (src_q.size() == 0 && exp_q.size() == 0 && !rd_last) done = 1'b1;
            else step(1'b0, 1'b1, 1'b0);
        end
        if (!done) check_eq("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        src_q.delete();
        step(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        int base_rd;
        int base_acc;
        rst             = 1'b1;
        bus.m_ready     = 1'b1;
        bus.fifo_empty  = 1'b1;
        bus.fifo_r_data = '0;

        // Reset held with data waiting downstream-ready.
        for (int i = 0; i < 5; i++) src_q.push_back(32'h1000 + i);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        src_q.delete();

        // Single word.
        base_rd = n_rd; base_acc = n_acc;
        src_q.push_back(32'hA5A5_0001);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
        check_eq("single_reads", n_rd - base_rd, 32'd1);
        check_eq("single_beats", n_acc - base_acc, 32'd1);

        // Streaming 12 words.
        do_reset();
        acc_cyc.delete();
        base_acc = n_acc;
        for (int i = 0; i < 12; i++) src_q.push_back(i);
        drain();
        check_eq("stream_beats", n_acc - base_acc, 32'd12);
        if (acc_cyc.size() == 12) check_eq("stream_span", acc_cyc[11] - acc_cyc[0], 32'd11);
        else check_eq("stream_count", acc_cyc.size(), 32'd12);

        // Backpressure.
        do_reset();
        base_rd = n_rd; base_acc = n_acc;
        for (int i = 0; i < 8; i++) src_q.push_back(i);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        check_eq("bp_reads", n_rd - base_rd, 32'd2);
        check_eq("bp_hold_data", bus.m_data, 32'd0);
        check_eq("bp_hold_valid", {31'b0, bus.m_valid}, 32'd1);
        drain();
        check_eq("bp_beats", n_acc - base_acc, 32'd8);

        // Reset after two beats of a burst.
        do_reset();
        base_acc = n_acc;
        for (int i = 0; i < 20; i++) src_q.push_back(32'h2000 + i);
        for (int i = 0; i < 20 && (n_acc - base_acc) < 2; i++) step(1'b0, 1'b1, 1'b0);
        check_eq("mid_beats", n_acc - base_acc, 32'd2);
        step(1'b1, 1'b1, 1'b0);
        check_eq("mid_rst_valid", {31'b0, bus.m_valid}, 32'd0);
        drain();

        // Random traffic.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) != 0 && src_q.size() < 6) src_q.push_back($urandom());
            gate_empty = ($urandom_range(0, 3) == 0);
            step(1'b0, $urandom_range(0, 2) != 0, 1'b0);
        end
        gate_empty = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
